dut_vector_engine: RTL and testbench

- Multi-cycle DUT vector sequencer; parametrised successor to the single-shot DUT interface.
- Pops stimulus words {hold count, mosi pattern} from a show-ahead stimulus FIFO and drives mosi for a programmable number of cycles.
- Captures miso into a result FIFO either once at the end of each hold or on every cycle of the hold (streaming mode).
- Sits between the stimulus/result FIFOs and the DUT pins, in the DUT clock domain.

---
 rtl/dut_vector_engine.sv | 194 +++++++++++++++++++
 tb/tb_dut_vector_engine.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dut_vector_engine.sv
`timescale 1ns/1ps
// dut_vector_engine
//   Multi-cycle DUT vector sequencer. Pops {hold count, mosi pattern} words
//   from a show-ahead stimulus FIFO, drives each pattern on mosi_data for
//   count+1 clocks and captures miso_data into a result FIFO, either once at
//   the end of the hold or on every hold cycle (streaming mode).
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_IDLE  | no vector on the pins; fetch when enabled and FIFO not empty
//   S_DRIVE | pattern on mosi_data; hold counter r_k runs 0..count
//
// Ports
//   clock, reset         DUT-domain clock, asynchronous active-high reset
//   enable               level, permits fetching new vectors
//   stream_mode          1 = capture every hold cycle, sampled at each fetch
//   busy / done          vector in progress / idle-because-empty pulse
//   overrun              sticky, a result was dropped on a full result FIFO
//   sfifo_*              stimulus FIFO read side {count, pattern}
//   rfifo_*              result FIFO write side {cycle index, miso}
//   mosi_data/miso_data  DUT pins
//   vec_count/drop_count statistics, live only with DUT_VECTOR_STATS_EN
//
// Build option
//   DUT_VECTOR_STATS_EN  adds saturating vector/drop counters; otherwise the
//                        counter outputs are tied to zero.

module dut_vector_engine #(
  parameter int STF_WIDTH   = 24,
  parameter int RTF_WIDTH   = 24,
  parameter int CYCLE_RANGE = 5,
  parameter int STAT_WIDTH  = 16
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               enable,
  input  logic                               stream_mode,
  output logic                               busy,
  output logic                               done,
  output logic                               overrun,
  input  logic [STF_WIDTH+CYCLE_RANGE:0]     sfifo_data,
  input  logic                               sfifo_rdempty,
  output logic                               sfifo_rdreq,
  output logic [RTF_WIDTH+CYCLE_RANGE:0]     rfifo_data,
  output logic                               rfifo_wrreq,
  input  logic                               rfifo_wrfull,
  output logic [STF_WIDTH-1:0]               mosi_data,
  input  logic [RTF_WIDTH-1:0]               miso_data,
  output logic [STAT_WIDTH-1:0]              vec_count,
  output logic [STAT_WIDTH-1:0]              drop_count
);

  localparam int CW = CYCLE_RANGE + 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRIVE = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CW-1:0]           r_k;
  logic [CW-1:0]           r_cnt;
  logic                    r_stream;
  logic [STF_WIDTH-1:0]    r_mosi;
  logic [RTF_WIDTH+CW-1:0] r_rdata;
  logic                    r_wrreq;
  logic                    r_done;
  logic                    r_overrun;

  logic                    w_last;
  logic                    w_fetch;
  logic                    w_capture;
  logic                    w_drop;
  logic [CW-1:0]           w_st_cnt;
  logic [STF_WIDTH-1:0]    w_st_pat;

  assign {w_st_cnt, w_st_pat} = sfifo_data;

  // The counter stops at r_cnt, so the all-ones count never wraps.
  assign w_last = (r_state == S_DRIVE) && (r_k == r_cnt);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fetch     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable && !sfifo_rdempty) begin
          w_fetch     = 1'b1;
          w_state_nxt = S_DRIVE;
        end
      end
      S_DRIVE: begin
        // Fetching on the last hold clock gives back-to-back vectors.
        if (w_last) begin
          if (enable && !sfifo_rdempty) begin
            w_fetch = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_capture = (r_state == S_DRIVE) && (r_stream || w_last);
  assign w_drop    = w_capture && rfifo_wrfull;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_k       <= '0;
      r_cnt     <= '0;
      r_stream  <= 1'b0;
      r_mosi    <= '0;
      r_rdata   <= '0;
      r_wrreq   <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_wrreq <= 1'b0;
      r_done  <= 1'b0;

      if (w_fetch) begin
        r_mosi   <= w_st_pat;
        r_cnt    <= w_st_cnt;
        r_stream <= stream_mode;
        r_k      <= '0;
      end else if ((r_state == S_DRIVE) && !w_last) begin
        r_k <= r_k + CW'(1);
      end

      // enable low at the end of a vector is a deliberate stop, not "empty".
      if (w_last && enable && sfifo_rdempty) begin
        r_done <= 1'b1;
      end

      // A full result FIFO never stalls the DUT; the result is discarded.
      if (w_capture) begin
        if (rfifo_wrfull) begin
          r_overrun <= 1'b1;
        end else begin
          r_wrreq <= 1'b1;
          r_rdata <= {r_k, miso_data};
        end
      end
    end
  end

  // Gated by reset so no pop can happen while the engine is held.
  assign sfifo_rdreq = w_fetch & ~reset;
  assign busy        = (r_state == S_DRIVE);
  assign done        = r_done;
  assign overrun     = r_overrun;
  assign rfifo_wrreq = r_wrreq;
  assign rfifo_data  = r_rdata;
  assign mosi_data   = r_mosi;

`ifdef DUT_VECTOR_STATS_EN
  logic [STAT_WIDTH-1:0] r_vec_count;
  logic [STAT_WIDTH-1:0] r_drop_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_vec_count  <= '0;
      r_drop_count <= '0;
    end else begin
      if (w_last && (r_vec_count != '1)) begin
        r_vec_count <= r_vec_count + STAT_WIDTH'(1);
      end
      if (w_drop && (r_drop_count != '1)) begin
        r_drop_count <= r_drop_count + STAT_WIDTH'(1);
      end
    end
  end

  assign vec_count  = r_vec_count;
  assign drop_count = r_drop_count;
`else
  logic w_drop_unused;
  assign w_drop_unused = w_drop;
  assign vec_count     = '0;
  assign drop_count    = '0;
`endif

endmodule

// File: tb/tb_dut_vector_engine.sv
`timescale 1ns/1ps
// tb_dut_vector_engine
//   Each scenario fills per-cycle stimulus tables, builds a per-cycle
//   expectation timeline from the vector list (vector i occupies count+1
//   clocks starting one clock after its fetch), then replays the stimulus
//   and compares every DUT output on the falling edge.

module tb_dut_vector_engine;

  localparam int SW   = 24;
  localparam int RW   = 24;
  localparam int CR   = 5;
  localparam int CW   = CR + 1;
  localparam int STW  = 16;
  localparam int MAXC = 1024;

  logic            clock = 1'b0;
  logic            reset;
  logic            enable;
  logic            stream_mode;
  logic            busy;
  logic            done;
  logic            overrun;
  logic [SW+CW-1:0] sfifo_data;
  logic            sfifo_rdempty;
  logic            sfifo_rdreq;
  logic [RW+CW-1:0] rfifo_data;
  logic            rfifo_wrreq;
  logic            rfifo_wrfull;
  logic [SW-1:0]   mosi_data;
  logic [RW-1:0]   miso_data;
  logic [STW-1:0]  vec_count;
  logic [STW-1:0]  drop_count;

  dut_vector_engine #(
    .STF_WIDTH(SW), .RTF_WIDTH(RW), .CYCLE_RANGE(CR), .STAT_WIDTH(STW)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .stream_mode(stream_mode),
    .busy(busy), .done(done), .overrun(overrun),
    .sfifo_data(sfifo_data), .sfifo_rdempty(sfifo_rdempty), .sfifo_rdreq(sfifo_rdreq),
    .rfifo_data(rfifo_data), .rfifo_wrreq(rfifo_wrreq), .rfifo_wrfull(rfifo_wrfull),
    .mosi_data(mosi_data), .miso_data(miso_data),
    .vec_count(vec_count), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  logic [SW+CW-1:0] sq[$];
  bit               pop_pend = 1'b0;

  bit            en_a[MAXC];
  bit            sm_a[MAXC];
  bit            wf_a[MAXC];
  bit            rs_a[MAXC];
  logic [RW-1:0] ms_a[MAXC];

  logic [SW-1:0]    e_mosi[MAXC];
  bit               mset[MAXC];
  bit               e_busy[MAXC];
  bit               e_rdreq[MAXC];
  bit               e_done[MAXC];
  bit               e_wr[MAXC];
  bit               e_ovr[MAXC];
  bit               dropped[MAXC];
  logic [RW+CW-1:0] e_data[MAXC];

  logic [SW-1:0] prev_mosi = '0;
  bit            prev_ovr  = 1'b0;
  int            exp_vec   = 0;
  int            exp_drop  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < MAXC; i++) begin
      en_a[i] = 0; sm_a[i] = 0; wf_a[i] = 0; rs_a[i] = 0; ms_a[i] = '0;
      e_mosi[i] = '0; mset[i] = 0; e_busy[i] = 0; e_rdreq[i] = 0;
      e_done[i] = 0; e_wr[i] = 0; e_ovr[i] = 0; dropped[i] = 0; e_data[i] = '0;
    end
  endtask

  task automatic push_vec(input int c, input logic [SW-1:0] p);
    sq.push_back({CW'(c), p});
  endtask

  // Vector driven on cycles s..s+c; fetched (and stream_mode sampled) at s-1.
  task automatic place_vec(input int s, input int c, input logic [SW-1:0] p);
    bit strm;
    int n;
    strm = sm_a[s-1];
    e_rdreq[s-1] = 1;
    for (int k = 0; k <= c; k++) begin
      n = s + k;
      e_mosi[n] = p;
      mset[n]   = 1;
      e_busy[n] = 1;
      if (strm || (k == c)) begin
        if (wf_a[n]) begin
          dropped[n] = 1;
          exp_drop++;
        end else begin
          e_wr[n+1]   = 1;
          e_data[n+1] = {CW'(k), ms_a[n]};
        end
      end
    end
    exp_vec++;
  endtask

  // mosi holds its last pattern; overrun is sticky from the clock after a drop.
  task automatic finalize(input int ncyc, input int rst_at);
    logic [SW-1:0] m;
    bit o;
    m = prev_mosi;
    o = prev_ovr;
    for (int n = 0; n < ncyc; n++) begin
      if (n > 0 && dropped[n-1]) o = 1;
      if (n == rst_at) begin m = '0; o = 0; end
      if (mset[n]) m = e_mosi[n];
      e_mosi[n] = m;
      e_ovr[n]  = o;
    end
    prev_mosi = m;
    prev_ovr  = o;
  endtask

  task automatic run(input string name, input int ncyc);
    for (int n = 0; n < ncyc; n++) begin
      @(posedge clock);
      if (pop_pend && sq.size() > 0) void'(sq.pop_front());
      #1;
      reset        = rs_a[n];
      enable       = en_a[n];
      stream_mode  = sm_a[n];
      miso_data    = ms_a[n];
      rfifo_wrfull = wf_a[n];
      sfifo_rdempty = (sq.size() == 0);
      sfifo_data    = (sq.size() == 0) ? '0 : sq[0];
      @(negedge clock);
      pop_pend = sfifo_rdreq;
      check($sformatf("%s.mosi@%0d", name, n), 64'(mosi_data), 64'(e_mosi[n]));
      check($sformatf("%s.busy@%0d", name, n), 64'(busy), 64'(e_busy[n]));
      check($sformatf("%s.rdreq@%0d", name, n), 64'(sfifo_rdreq), 64'(e_rdreq[n]));
      check($sformatf("%s.done@%0d", name, n), 64'(done), 64'(e_done[n]));
      check($sformatf("%s.wrreq@%0d", name, n), 64'(rfifo_wrreq), 64'(e_wr[n]));
      check($sformatf("%s.overrun@%0d", name, n), 64'(overrun), 64'(e_ovr[n]));
      if (e_wr[n])
        check($sformatf("%s.rdata@%0d", name, n), 64'(rfifo_data), 64'(e_data[n]));
    end
  endtask

  task automatic check_stats(input string name);
`ifdef DUT_VECTOR_STATS_EN
    check({name, ".vec_count"}, 64'(vec_count), 64'(exp_vec));
    check({name, ".drop_count"}, 64'(drop_count), 64'(exp_drop));
`else
    check({name, ".vec_count"}, 64'(vec_count), 64'd0);
    check({name, ".drop_count"}, 64'(drop_count), 64'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int c;
    logic [SW-1:0] p;

    reset = 1'b1; enable = 1'b0; stream_mode = 1'b0; miso_data = '0;
    rfifo_wrfull = 1'b0; sfifo_rdempty = 1'b1; sfifo_data = '0;

    // Reset state, enable high with an empty FIFO.
    clear_model();
    for (int n = 0; n < 3; n++) begin rs_a[n] = 1; en_a[n] = 1; end
    finalize(3, 0);
    run("rst", 3);
    check_stats("rst");

    // One end-mode vector, c=3.
    clear_model();
    for (int n = 0; n < 8; n++) begin en_a[n] = 1; ms_a[n] = 24'h123456; end
    push_vec(3, 24'hA5A5A5);
    place_vec(1, 3, 24'hA5A5A5);
    e_done[5] = 1;
    finalize(8, -1);
    run("one", 8);
    check_stats("one");

    // Streaming, c=2, miso 1,2,3.
    clear_model();
    for (int n = 0; n < 7; n++) en_a[n] = 1;
    sm_a[0] = 1;
    ms_a[1] = 1; ms_a[2] = 2; ms_a[3] = 3;
    push_vec(2, 24'h00C3C3);
    place_vec(1, 2, 24'h00C3C3);
    e_done[4] = 1;
    finalize(7, -1);
    run("stream", 7);
    check_stats("stream");

    // Three c=0 vectors back to back.
    clear_model();
    for (int n = 0; n < 8; n++) begin en_a[n] = 1; ms_a[n] = RW'(n * 17 + 5); end
    for (int i = 1; i <= 3; i++) begin
      push_vec(0, SW'(i));
      place_vec(i, 0, SW'(i));
    end
    e_done[4] = 1;
    finalize(8, -1);
    run("b2b", 8);
    check_stats("b2b");

    // Result FIFO full at the end-mode capture of a c=1 vector.
    clear_model();
    for (int n = 0; n < 8; n++) begin en_a[n] = 1; ms_a[n] = RW'(24'h5A0000 + n); end
    wf_a[2] = 1;
    push_vec(1, 24'h111111);
    push_vec(1, 24'h222222);
    place_vec(1, 1, 24'h111111);
    place_vec(3, 1, 24'h222222);
    e_done[5] = 1;
    finalize(8, -1);
    run("full", 8);
    check_stats("full");

    // Reset on k=2 of a c=5 streaming vector, then a normal c=1 vector.
    clear_model();
    for (int n = 0; n < 11; n++) begin en_a[n] = 1; ms_a[n] = RW'($urandom()); end
    sm_a[0] = 1;
    rs_a[3] = 1; rs_a[4] = 1;
    push_vec(5, 24'hBEEF01);
    push_vec(1, 24'h0F0F0F);
    place_vec(1, 5, 24'hBEEF01);
    for (int n = 3; n < MAXC; n++) begin
      mset[n] = 0; e_busy[n] = 0; e_wr[n] = 0; e_rdreq[n] = 0; e_done[n] = 0; dropped[n] = 0;
    end
    exp_vec = 0;
    exp_drop = 0;
    place_vec(6, 1, 24'h0F0F0F);
    e_done[8] = 1;
    finalize(11, 3);
    run("midrst", 11);
    check_stats("midrst");

    // enable dropped during a c=4 vector with two more queued.
    clear_model();
    for (int n = 0; n < 17; n++) begin
      en_a[n] = (n < 3 || n >= 9);
      ms_a[n] = RW'($urandom());
    end
    push_vec(4, 24'hABCDEF);
    push_vec(0, 24'h000777);
    push_vec(2, 24'h999000);
    place_vec(1, 4, 24'hABCDEF);
    place_vec(10, 0, 24'h000777);
    place_vec(11, 2, 24'h999000);
    e_done[14] = 1;
    finalize(17, -1);
    run("endrop", 17);
    check_stats("endrop");

    // Randomised back-to-back run with random mode, miso and full flags.
    clear_model();
    for (int n = 0; n < MAXC; n++) begin
      en_a[n] = 1;
      sm_a[n] = $urandom_range(0, 1);
      ms_a[n] = RW'($urandom());
      wf_a[n] = ($urandom_range(0, 5) == 0);
    end
    s = 1;
    for (int i = 0; i < 30; i++) begin
      if (i == 0) c = 0;
      else if (i == 5) c = (1 << CW) - 1;
      else c = $urandom_range(0, 6);
      p = SW'($urandom());
      push_vec(c, p);
      place_vec(s, c, p);
      s = s + c + 1;
    end
    e_done[s] = 1;
    finalize(s + 3, -1);
    run("rand", s + 3);
    check_stats("rand");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
